// File: rtl/mm_systolic_pkg.sv
// ---------------------------------------------------------------------------
// mm_systolic_pkg
// Shared constants and types for the 8x8 int8 outer-product systolic array.
//   N         : array dimension (PEs per row/column, bytes per bar)
//   DATA_W    : operand width (signed int8)
//   ACC_W_DEF : default accumulator width; 24 bits holds the exact sum of
//               up to 256 bars of int8 x int8 products
//   BAR_W     : width of one row_bar / col_bar word
// Optional build macro used by mm_systolic: MM_SYSTOLIC_SAT_EN.
// ---------------------------------------------------------------------------
package mm_systolic_pkg;

    localparam int N         = 8;
    localparam int DATA_W    = 8;
    localparam int ACC_W_DEF = 24;
    localparam int BAR_W     = N * DATA_W;

    typedef logic signed [DATA_W-1:0]    int8_t;
    typedef logic signed [ACC_W_DEF-1:0] acc_t;

    // Byte idx of a bar word; byte 0 occupies the MSBs.
    function automatic int8_t bar_byte(input logic [BAR_W-1:0] bar, input int idx);
        return int8_t'(bar[BAR_W-1-DATA_W*idx -: DATA_W]);
    endfunction

endpackage

// File: rtl/mm_pe.sv
// ---------------------------------------------------------------------------
// mm_pe
// One multiply-accumulate cell of the systolic array. The A operand enters
// from the left and is passed right one cycle later; the B operand enters
// from above and is passed down one cycle later. When both operand valids
// are high the signed 16-bit product is sign-extended and added into the
// accumulator, which wraps modulo 2^ACC_W.
// Ports:
//   clk, rst         : clock, synchronous active-high reset
//   clr_i            : flush - clears accumulator and pass-through state
//   a_i / a_v_i      : A operand and valid from the left neighbour
//   b_i / b_v_i      : B operand and valid from the upper neighbour
//   a_o / a_v_o      : registered A operand and valid to the right
//   b_o / b_v_o      : registered B operand and valid downwards
//   acc_o            : accumulator value
// ---------------------------------------------------------------------------
module mm_pe
    import mm_systolic_pkg::*;
#(
    parameter int ACC_W = ACC_W_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clr_i,
    input  int8_t                   a_i,
    input  logic                    a_v_i,
    input  int8_t                   b_i,
    input  logic                    b_v_i,
    output int8_t                   a_o,
    output logic                    a_v_o,
    output int8_t                   b_o,
    output logic                    b_v_o,
    output logic signed [ACC_W-1:0] acc_o
);

    logic signed [2*DATA_W-1:0] prod;
    logic signed [ACC_W-1:0]    acc_q, acc_d;
    int8_t                      a_q, b_q;
    logic                       a_v_q, b_v_q;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        acc_d = acc_q;
        prod  = 16'(a_i) * 16'(b_i);
        if (a_v_i && b_v_i) begin
            acc_d = acc_q + ACC_W'(prod);
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples the
        // pre-edge values of its neighbours, which is what makes the
        // operands march one PE per cycle.
        if (rst || clr_i) begin
            a_q   <= '0;
            b_q   <= '0;
            a_v_q <= 1'b0;
            b_v_q <= 1'b0;
            acc_q <= '0;
        end else begin
            a_q   <= a_i;
            b_q   <= b_i;
            a_v_q <= a_v_i;
            b_v_q <= b_v_i;
            acc_q <= acc_d;
        end
    end

    assign a_o   = a_q;
    assign a_v_o = a_v_q;
    assign b_o   = b_q;
    assign b_v_o = b_v_q;
    assign acc_o = acc_q;

endmodule

// File: rtl/mm_systolic.sv
// ---------------------------------------------------------------------------
// mm_systolic
// 8x8 output-stationary systolic array computing C = sum_k A[:,k] (x) B[k,:]
// from a stream of bars (one A column + one B row per cycle). Row byte i is
// delayed through an (i+1)-deep skew line into PE(i,0); column byte j
// through a (j+1)-deep line into PE(0,j). A bar accepted at edge t is in
// acc(i,j) at edge t+i+j+1 and in res at edge t+i+j+2.
// Ports:
//   clk, rst    : clock, synchronous active-high reset (priority over all)
//   row_bar     : eight int8 A-column elements, byte 0 in MSBs
//   col_bar     : eight int8 B-row elements, byte 0 in MSBs
//   bar_valid   : row_bar/col_bar carry a k-slice this cycle
//   flush       : clear accumulators and in-flight data (beats bar_valid)
//   res         : registered int8 results res[i][j]
//   res_valid   : res is final for every bar accepted since the last flush
// Build macro: MM_SYSTOLIC_SAT_EN - when defined res saturates to
// [-128,127]; when undefined res is the low byte of the accumulator.
// ---------------------------------------------------------------------------
module mm_systolic
    import mm_systolic_pkg::*;
#(
    parameter int ACC_W = ACC_W_DEF
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [BAR_W-1:0]                     row_bar,
    input  logic [BAR_W-1:0]                     col_bar,
    input  logic                                 bar_valid,
    input  logic                                 flush,
    output logic [N-1:0][N-1:0][DATA_W-1:0]      res,
    output logic                                 res_valid
);

    // A bar presented together with flush is dropped.
    logic accept;
    assign accept = bar_valid && !flush;

    // Operand mesh: a_h[i][j] feeds PE(i,j) from the left, b_d[i][j] from
    // above. Index N on each is the unused output of the last PE.
    int8_t a_h  [N][N+1];
    logic  a_vh [N][N+1];
    int8_t b_d  [N+1][N];
    logic  b_vd [N+1][N];

    logic signed [ACC_W-1:0]         acc [N][N];
    logic [N-1:0][N-1:0][DATA_W-1:0] res_d, res_q;
    logic [N-1:0]                    skew_busy;
    logic [N*N-1:0]                  pe_busy;
    logic                            any_busy;
    logic                            seen_q, res_valid_q;

    // ---------------- skew delay lines ----------------
    for (genvar gi = 0; gi < N; gi++) begin : g_skew
        int8_t       row_q [gi+1];
        int8_t       col_q [gi+1];
        logic [gi:0] row_v_q;
        logic [gi:0] col_v_q;
        logic        unused_edge;

        always_ff @(posedge clk) begin
            if (rst || flush) begin
                // NOTE: the data stages are cleared along with the valids;
                // the valids alone gate accumulation, but clearing the data
                // keeps every flop at a known value after reset.
                for (int k = 0; k <= gi; k++) begin
                    row_q[k] <= '0;
                    col_q[k] <= '0;
                end
                row_v_q <= '0;
                col_v_q <= '0;
            end else begin
                row_q[0]   <= bar_byte(row_bar, gi);
                col_q[0]   <= bar_byte(col_bar, gi);
                row_v_q[0] <= accept;
                col_v_q[0] <= accept;
                for (int k = 1; k <= gi; k++) begin
                    row_q[k]   <= row_q[k-1];
                    col_q[k]   <= col_q[k-1];
                    row_v_q[k] <= row_v_q[k-1];
                    col_v_q[k] <= col_v_q[k-1];
                end
            end
        end

        assign a_h[gi][0]    = row_q[gi];
        assign a_vh[gi][0]   = row_v_q[gi];
        assign b_d[0][gi]    = col_q[gi];
        assign b_vd[0][gi]   = col_v_q[gi];
        assign skew_busy[gi] = (|row_v_q) || (|col_v_q);

        // Data leaving the far edge of the array has no consumer.
        assign unused_edge = ^{a_h[gi][N], b_d[N][gi]};
    end

    // ---------------- PE array ----------------
    for (genvar gi = 0; gi < N; gi++) begin : g_row
        for (genvar gj = 0; gj < N; gj++) begin : g_col
            mm_pe #(
                .ACC_W (ACC_W)
            ) u_pe (
                .clk   (clk),
                .rst   (rst),
                .clr_i (flush),
                .a_i   (a_h[gi][gj]),
                .a_v_i (a_vh[gi][gj]),
                .b_i   (b_d[gi][gj]),
                .b_v_i (b_vd[gi][gj]),
                .a_o   (a_h[gi][gj+1]),
                .a_v_o (a_vh[gi][gj+1]),
                .b_o   (b_d[gi+1][gj]),
                .b_v_o (b_vd[gi+1][gj]),
                .acc_o (acc[gi][gj])
            );

            assign pe_busy[gi*N+gj] = a_vh[gi][gj+1] || b_vd[gi+1][gj];

`ifdef MM_SYSTOLIC_SAT_EN
            localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(127);
            localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-128);
            assign res_d[gi][gj] = (acc[gi][gj] > SAT_MAX) ? 8'h7F :
                                   (acc[gi][gj] < SAT_MIN) ? 8'h80 :
                                   acc[gi][gj][DATA_W-1:0];
`else
            logic unused_acc_hi;
            assign res_d[gi][gj] = acc[gi][gj][DATA_W-1:0];
            assign unused_acc_hi = ^acc[gi][gj][ACC_W-1:DATA_W];
`endif
        end
    end

    assign any_busy = (|skew_busy) || (|pe_busy);

    // ---------------- result and status registers ----------------
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            res_q       <= '0;
            seen_q      <= 1'b0;
            res_valid_q <= 1'b0;
        end else begin
            res_q <= res_d;
            if (accept) begin
                seen_q <= 1'b1;
            end
            // A bar being accepted this edge is about to be in flight, so
            // results cannot be declared final on the same edge.
            res_valid_q <= seen_q && !any_busy && !accept;
        end
    end

    assign res       = res_q;
    assign res_valid = res_valid_q;

endmodule

// File: tb/tb_mm_systolic.sv
// ---------------------------------------------------------------------------
// tb_mm_systolic
// Directed bench for mm_systolic: single bar with latency points, random
// bars against a reference sum, 127x127 overflow, flush mid-stream, gapped
// bars with garbage data, and reset mid-stream. Inputs change on the
// falling edge; outputs are sampled on the falling edge. Honours
// MM_SYSTOLIC_SAT_EN for the expected result format.
// ---------------------------------------------------------------------------
module tb_mm_systolic;
    import mm_systolic_pkg::*;

    logic                            clk = 1'b0;
    logic                            rst;
    logic [BAR_W-1:0]                row_bar;
    logic [BAR_W-1:0]                col_bar;
    logic                            bar_valid;
    logic                            flush;
    logic [N-1:0][N-1:0][DATA_W-1:0] res;
    logic                            res_valid;

    int checks   = 0;
    int failures = 0;

    // Bars accepted since the last flush/reset, for the reference sum.
    logic [BAR_W-1:0] m_row[$];
    logic [BAR_W-1:0] m_col[$];

    always #5 clk = ~clk;

    mm_systolic dut (
        .clk       (clk),
        .rst       (rst),
        .row_bar   (row_bar),
        .col_bar   (col_bar),
        .bar_valid (bar_valid),
        .flush     (flush),
        .res       (res),
        .res_valid (res_valid)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [BAR_W-1:0] rep(input logic [7:0] b);
        return {8{b}};
    endfunction

    function automatic logic [7:0] finalize(input int s);
`ifdef MM_SYSTOLIC_SAT_EN
        if (s > 127)  return 8'h7F;
        if (s < -128) return 8'h80;
`endif
        return s[7:0];
    endfunction

    function automatic logic [7:0] model_res(input int i, input int j);
        int s = 0;
        foreach (m_row[k]) begin
            logic signed [7:0] a;
            logic signed [7:0] b;
            a = m_row[k][BAR_W-1-8*i -: 8];
            b = m_col[k][BAR_W-1-8*j -: 8];
            s += int'(a) * int'(b);
        end
        return finalize(s);
    endfunction

    // One clock: drive on the falling edge, record accepted bars.
    task automatic step(input logic v, input logic [BAR_W-1:0] r, input logic [BAR_W-1:0] c);
        @(negedge clk);
        rst       = 1'b0;
        flush     = 1'b0;
        bar_valid = v;
        row_bar   = r;
        col_bar   = c;
        if (v) begin
            m_row.push_back(r);
            m_col.push_back(c);
        end
    endtask

    // Idle cycles with garbage on the data buses.
    task automatic idle(input int n);
        repeat (n) step(1'b0, {$urandom, $urandom}, {$urandom, $urandom});
    endtask

    // Flush with a bar presented alongside; the bar must be discarded.
    task automatic do_flush();
        @(negedge clk);
        rst       = 1'b0;
        flush     = 1'b1;
        bar_valid = 1'b1;
        row_bar   = rep(8'h55);
        col_bar   = rep(8'h33);
        m_row.delete();
        m_col.delete();
    endtask

    // Reset with flush and a bar asserted as well; reset wins.
    task automatic do_reset();
        @(negedge clk);
        rst       = 1'b1;
        flush     = 1'b1;
        bar_valid = 1'b1;
        row_bar   = rep(8'h7F);
        col_bar   = rep(8'h11);
        m_row.delete();
        m_col.delete();
    endtask

    task automatic check_all(input string tag, input logic [7:0] exp);
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
                check($sformatf("%s[%0d][%0d]", tag, i, j), 64'(res[i][j]), 64'(exp));
    endtask

    task automatic check_model(input string tag);
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
                check($sformatf("%s[%0d][%0d]", tag, i, j), 64'(res[i][j]), 64'(model_res(i, j)));
    endtask

    initial begin
        rst       = 1'b1;
        flush     = 1'b0;
        bar_valid = 1'b0;
        row_bar   = '0;
        col_bar   = '0;
        repeat (3) @(negedge clk);

        // Reset state.
        step(1'b0, '0, '0);
        check("reset_res_zero", 64'(res == '0), 64'd1);
        check("reset_res_valid", 64'(res_valid), 64'd0);

        // Single bar 1s x 2s: latency points then final value.
        step(1'b1, rep(8'h01), rep(8'h02));   // accepted at edge t
        step(1'b0, '0, '0);                   // after t
        step(1'b0, '0, '0);                   // after t+1
        check("lat_res00_t1", 64'(res[0][0]), 64'd0);
        check("lat_valid_t1", 64'(res_valid), 64'd0);
        step(1'b0, '0, '0);                   // after t+2
        check("lat_res00_t2", 64'(res[0][0]), 64'd2);
        check("lat_res77_t2", 64'(res[7][7]), 64'd0);
        idle(13);                             // after t+15
        check("lat_res77_t15", 64'(res[7][7]), 64'd0);
        check("lat_valid_t15", 64'(res_valid), 64'd0);
        step(1'b0, '0, '0);                   // after t+16
        check("lat_res77_t16", 64'(res[7][7]), 64'd2);
        idle(20);
        check_all("single", 8'h02);
        check("single_valid", 64'(res_valid), 64'd1);

        // Random bars against the reference sum.
        do_flush();
        step(1'b0, '0, '0);
        check("flush_valid_clear", 64'(res_valid), 64'd0);
        check("flush_res_zero", 64'(res == '0), 64'd1);
        for (int k = 0; k < 128; k++) step(1'b1, {$urandom, $urandom}, {$urandom, $urandom});
        idle(20);
        check_model("rand");
        check("rand_valid", 64'(res_valid), 64'd1);

        // 128 x 127 x 127 = 2064512 = 0x1F8080.
        do_flush();
        for (int k = 0; k < 128; k++) step(1'b1, rep(8'h7F), rep(8'h7F));
        idle(20);
`ifdef MM_SYSTOLIC_SAT_EN
        check_all("big", 8'h7F);
`else
        check_all("big", 8'h80);
`endif

        // Flush while four bars are in flight, then 3 x -1.
        do_flush();
        for (int k = 0; k < 4; k++) step(1'b1, {$urandom, $urandom}, {$urandom, $urandom});
        do_flush();
        step(1'b1, rep(8'h03), rep(8'hFF));
        idle(20);
        check_all("flush", 8'hFD);
        check("flush_new_valid", 64'(res_valid), 64'd1);

        // Gapped bars with garbage in the gaps.
        do_flush();
        step(1'b1, 64'h0102_0304_0506_0708, 64'hFFFE_FDFC_FBFA_F9F8);
        idle(3);
        step(1'b1, 64'h8081_7F7E_0010_F0E0, 64'h1020_3040_5060_7080);
        idle(3);
        step(1'b1, 64'hFF01_FF01_FF01_FF01, 64'h7F80_7F80_7F80_7F80);
        idle(3);
        step(1'b1, 64'h0A0B_0C0D_0E0F_1011, 64'h0303_0303_FDFD_FDFD);
        idle(20);
        check_model("gaps");
        check("gaps_valid", 64'(res_valid), 64'd1);

        // Reset mid-stream, then 1 x 5.
        do_flush();
        for (int k = 0; k < 5; k++) step(1'b1, {$urandom, $urandom}, {$urandom, $urandom});
        do_reset();
        step(1'b0, '0, '0);
        check("rst_res_zero", 64'(res == '0), 64'd1);
        check("rst_valid_clear", 64'(res_valid), 64'd0);
        step(1'b1, rep(8'h01), rep(8'h05));
        step(1'b0, '0, '0);
        step(1'b0, '0, '0);
        check("rst_valid_inflight", 64'(res_valid), 64'd0);
        idle(20);
        check_all("rst", 8'h05);
        check("rst_valid", 64'(res_valid), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mm_systolic.md
MM_SYSTOLIC -- requirements
Module: mm_systolic

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 Port clk, input, 1 bit: rising-edge clock for all state.
REQ-003 Port rst, input, 1 bit: synchronous active-high reset.
REQ-004 Port row_bar, input, 64 bits: eight signed int8 A-column elements; byte i at bits [63-8i -: 8] is A[i][k] (byte 0 in MSBs).
REQ-005 Port col_bar, input, 64 bits: eight signed int8 B-row elements; byte j at bits [63-8j -: 8] is B[k][j].
REQ-006 Port bar_valid, input, 1 bit: row_bar/col_bar carry one valid k-slice this cycle.
REQ-007 Port flush, input, 1 bit: clear all accumulators and in-flight data to start a new product.
REQ-008 Port res, output, 8x8x8 bits: signed int8 results, indexed res[i][j], registered, also visible as internal array res[i][j].
REQ-009 Port res_valid, output, 1 bit: res is final for all bars since the last flush.
REQ-010 Parameter ACC_W, default 24: accumulator width per PE (exact sums for up to 256 bars).

Function
REQ-011 The block SHALL compute C = sum over accepted bars k of A[:,k] outer B[k,:], i.e. C[i][j] = sum_k row_k[i]*col_k[j], signed.
REQ-012 The array SHALL be 8x8 PEs; row byte i enters PE(i,0) delayed i cycles; col byte j enters PE(0,j) delayed j cycles; operands move one PE right/down per cycle with a valid bit.
REQ-013 Each PE SHALL form a signed 8x8=16-bit product and add it sign-extended into its ACC_W accumulator when its operand valid is high; accumulator wraps modulo 2^ACC_W.
REQ-014 Bars SHALL be accepted every cycle bar_valid=1, back-to-back, no stall, no backpressure.
REQ-015 Latency: the contribution of a bar accepted at edge t SHALL be in acc(i,j) by edge t+i+j+1 and in res by edge t+i+j+2; all of res final within 16 cycles after the last bar.
REQ-016 res[i][j] SHALL be derived from acc(i,j) per REQ-024 and registered each cycle.
REQ-017 res_valid SHALL be 1 when at least one bar was accepted since flush/reset and no valid operand is in any skew register or PE pipeline; 0 otherwise.
REQ-018 flush=1 at an edge SHALL zero all accumulators, res, operand valids and res_valid; a bar presented with flush=1 is discarded (flush has priority).
REQ-019 bar_valid=0 cycles between bars SHALL not change results (gaps allowed).
REQ-020 Data on row_bar/col_bar with bar_valid=0 SHALL be ignored.

Reset
REQ-021 rst=1 at an edge SHALL clear accumulators, skew/pipeline registers, valids, res to 0 and res_valid to 0.
REQ-022 rst SHALL take priority over flush and bar_valid; reset mid-stream discards all partial sums.
REQ-023 No flush is required after reset before the first bar.

Configuration
REQ-024 Macro MM_SYSTOLIC_SAT_EN: defined -> res[i][j] = acc(i,j) saturated to [-128,127]; undefined -> res[i][j] = acc(i,j)[7:0] (two's-complement wrap).

Structure
REQ-025 Package mm_systolic_pkg SHALL hold N=8, DATA_W=8, default ACC_W, and the int8/accumulator typedefs.
REQ-026 One sub-module mm_pe (one MAC cell: operand pass-through regs, valid, accumulator, flush clear) SHALL be instantiated 64 times; skew delay lines live in mm_systolic.

Verification
REQ-027 Single bar row=all 1, col=all 2, then idle 20 cycles -> every res=2, res_valid=1.
REQ-028 128 bars of random int8 vs golden model; compare after 20 idle cycles -> all 64 match (wrap or saturate per macro).
REQ-029 128 bars row=all 127, col=all 127 -> acc=2064512; no macro res=0x80 (-128); with macro res=127.
REQ-030 Accumulate 4 bars, flush, then one bar row=3s, col=-1s -> every res=-3 (earlier data gone).
REQ-031 Bars with 3-cycle bar_valid gaps and garbage data during gaps -> results identical to back-to-back run.
REQ-032 rst pulsed mid-stream, then one bar row=1, col=5 -> every res=5; res_valid 0 while operands in flight.
